mem_bus_arbiter: RTL and testbench

//  Shares the CPU's single-port 16-bit memory between instruction fetch, data load/store
//  and (optionally) a program loader. Sits between the CPU core and the memory macro.
//  One access in flight at a time. Requester handshake is Req/Ready, with an RValid completion pulse.

---
 rtl/cpu_mem_pkg.sv | 26 ++
 rtl/rr_pick.sv | 37 +++
 rtl/mem_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared constants and types for the CPU memory bus arbiter.
// MEM_ARB_LOADER_EN adds the loader port as a third requester.
package cpu_mem_pkg;

   localparam int DATA_W_DFLT = 16;
   localparam int ADDR_W_DFLT = 16;

`ifdef MEM_ARB_LOADER_EN
   localparam int NUM_PORTS = 3;
`else
   localparam int NUM_PORTS = 2;
`endif

   localparam int PORT_F = 0;
   localparam int PORT_D = 1;
   localparam int PORT_L = 2;

   // Pointer holds the last granted port; the last index yields F,D,L after reset.
   localparam logic [1:0] PTR_RESET = 2'(NUM_PORTS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner select: first requester after the last grant.
module rr_pick
   import cpu_mem_pkg::*;
#(
   parameter int N = NUM_PORTS
) (
   input  logic [N-1:0] req,
   input  logic [1:0]   last,
   output logic         found,
   output logic [1:0]   pick
);

   logic [2*N-1:0] dbl;
   logic [2*N-1:0] shifted;
   logic [N-1:0]   rot;
   int             sh;
   int             idx;

   always_comb begin
      dbl     = {req, req};
      sh      = int'(last) + 1;
      shifted = dbl >> sh;
      rot     = shifted[N-1:0];
      found   = 1'b0;
      pick    = last;
      idx     = 0;
      // rot[0] is the port right after the last grant, so the lowest set bit wins.
      for (int k = 0; k < N; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            idx   = (int'(last) + 1 + k) % N;
            pick  = 2'(idx);
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port memory arbiter for fetch, data and optional loader requesters.
// MEM_ARB_LOADER_EN enables the L_* port and 3-way round-robin.
module mem_bus_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DFLT,
   parameter int ADDR_W  = ADDR_W_DFLT,
   parameter int MEM_LAT = 2
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              F_Req,
   input  logic [ADDR_W-1:0] F_Addr,
   output logic              F_Ready,
   output logic              F_RValid,
   output logic [DATA_W-1:0] F_RData,
   input  logic              D_Req,
   input  logic              D_We,
   input  logic [ADDR_W-1:0] D_Addr,
   input  logic [DATA_W-1:0] D_WData,
   output logic              D_Ready,
   output logic              D_RValid,
   output logic [DATA_W-1:0] D_RData,
`ifdef MEM_ARB_LOADER_EN
   input  logic              L_Req,
   input  logic              L_We,
   input  logic [ADDR_W-1:0] L_Addr,
   input  logic [DATA_W-1:0] L_WData,
   output logic              L_Ready,
   output logic              L_RValid,
   output logic [DATA_W-1:0] L_RData,
`endif
   output logic              Mem_En,
   output logic              Mem_We,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [DATA_W-1:0] Mem_WData,
   input  logic [DATA_W-1:0] Mem_RData,
   output logic              dbg_state
);

   // Handshake: a requester's x_Ready is high only in the cycle its Req is granted;
   // address/we/wdata are sampled in that cycle, and x_RValid pulses once at completion.
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   arb_state_t        state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [1:0]        owner, last_ptr, pick;
   logic              owner_we, found, grant, done;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   logic [NUM_PORTS-1:0] req, we_v, ready, rvalid_q;
   logic [ADDR_W-1:0]    addr_v  [NUM_PORTS];
   logic [DATA_W-1:0]    wdata_v [NUM_PORTS];
   logic [DATA_W-1:0]    rdata_q [NUM_PORTS];

   assign req[PORT_F]     = F_Req;
   assign we_v[PORT_F]    = 1'b0;
   assign addr_v[PORT_F]  = F_Addr;
   assign wdata_v[PORT_F] = '0;
   assign req[PORT_D]     = D_Req;
   assign we_v[PORT_D]    = D_We;
   assign addr_v[PORT_D]  = D_Addr;
   assign wdata_v[PORT_D] = D_WData;
`ifdef MEM_ARB_LOADER_EN
   assign req[PORT_L]     = L_Req;
   assign we_v[PORT_L]    = L_We;
   assign addr_v[PORT_L]  = L_Addr;
   assign wdata_v[PORT_L] = L_WData;
`endif

   rr_pick #(.N(NUM_PORTS)) u_pick (
      .req   (req),
      .last  (last_ptr),
      .found (found),
      .pick  (pick)
   );

   // Reset gates the grant so Ready/Mem_* stay low while Reset_n is held.
   assign grant = Reset_n && (state == IDLE) && found;
   assign done  = (state == BUSY) && (cnt == '0);

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant) state_nxt = BUSY;
         BUSY:    if (done)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign dbg_state = (state == BUSY);

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      ready     = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (pick == 2'(p)) begin
            sel_we    = we_v[p];
            sel_addr  = addr_v[p];
            sel_wdata = wdata_v[p];
            ready[p]  = grant;
         end
      end
      Mem_En    = grant;
      Mem_We    = grant & sel_we;
      Mem_Addr  = grant ? sel_addr  : '0;
      Mem_WData = grant ? sel_wdata : '0;
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt      <= '0;
         owner    <= '0;
         owner_we <= 1'b0;
         last_ptr <= PTR_RESET;
      end else if (grant) begin
         cnt      <= CW'(MEM_LAT - 1);
         owner    <= pick;
         owner_we <= sel_we;
         last_ptr <= pick;
      end else if ((state == BUSY) && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   // Mem_RData is valid in the cycle the counter reaches zero; writes leave RData untouched.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         rvalid_q <= '0;
         for (int p = 0; p < NUM_PORTS; p++) rdata_q[p] <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            rvalid_q[p] <= done && (owner == 2'(p));
            if (done && (owner == 2'(p)) && !owner_we) rdata_q[p] <= Mem_RData;
         end
      end
   end

   assign F_Ready  = ready[PORT_F];
   assign F_RValid = rvalid_q[PORT_F];
   assign F_RData  = rdata_q[PORT_F];
   assign D_Ready  = ready[PORT_D];
   assign D_RValid = rvalid_q[PORT_D];
   assign D_RData  = rdata_q[PORT_D];
`ifdef MEM_ARB_LOADER_EN
   assign L_Ready  = ready[PORT_L];
   assign L_RValid = rvalid_q[PORT_L];
   assign L_RData  = rdata_q[PORT_L];
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (MEM_LAT=2) with a behavioural memory model.
// Loader scenario runs only when MEM_ARB_LOADER_EN is defined.
module tb_mem_bus_arbiter;

   logic        Clock = 1'b0;
   logic        Reset_n = 1'b0;
   logic        F_Req = 1'b0, D_Req = 1'b0, D_We = 1'b0;
   logic [15:0] F_Addr = '0, D_Addr = '0, D_WData = '0;
   logic        F_Ready, F_RValid, D_Ready, D_RValid;
   logic [15:0] F_RData, D_RData;
`ifdef MEM_ARB_LOADER_EN
   logic        L_Req = 1'b0, L_We = 1'b0;
   logic [15:0] L_Addr = '0, L_WData = '0;
   logic        L_Ready, L_RValid;
   logic [15:0] L_RData;
`endif
   logic        Mem_En, Mem_We;
   logic [15:0] Mem_Addr, Mem_WData, Mem_RData;
   logic        dbg_state;

   int          total = 0;
   int          bad = 0;
   logic [15:0] exp_q[$];

   mem_bus_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(2)) dut (
      .Clock(Clock), .Reset_n(Reset_n),
      .F_Req(F_Req), .F_Addr(F_Addr), .F_Ready(F_Ready), .F_RValid(F_RValid), .F_RData(F_RData),
      .D_Req(D_Req), .D_We(D_We), .D_Addr(D_Addr), .D_WData(D_WData),
      .D_Ready(D_Ready), .D_RValid(D_RValid), .D_RData(D_RData),
`ifdef MEM_ARB_LOADER_EN
      .L_Req(L_Req), .L_We(L_We), .L_Addr(L_Addr), .L_WData(L_WData),
      .L_Ready(L_Ready), .L_RValid(L_RValid), .L_RData(L_RData),
`endif
      .Mem_En(Mem_En), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
      .Mem_RData(Mem_RData), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 Clock = ~Clock;

   initial begin
      #20000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1);
   end

   // memory model: word a initialises to a ^ 16'hA5A5, read data two cycles after Mem_En
   logic        mem_init_done = 1'b0;
   logic [15:0] mem [1024];
   logic [15:0] rd_pipe0, rd_pipe1;
   assign Mem_RData = rd_pipe1;

   always @(posedge Clock) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 16'(i) ^ 16'hA5A5;
         mem_init_done <= 1'b1;
      end else if (Mem_En && Mem_We) begin
         mem[Mem_Addr[9:0]] <= Mem_WData;
      end
      rd_pipe0 <= mem[Mem_Addr[9:0]];
      rd_pipe1 <= rd_pipe0;
   end

   // checking
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, want);
      end
   endtask

   // driver helpers
   task automatic cyc();
      @(negedge Clock);
   endtask

   task automatic wait_done(input int port, output int n);
      n = -1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge Clock);
         #1;
         if ((port == 0 && F_RValid) || (port == 1 && D_RValid)) begin
            n = k;
            break;
         end
      end
   endtask

   int n;
   int rv_cnt;
   int g_port[$];
   int g_cyc[$];
   logic [15:0] f_last;

   initial begin
      // 1: reset state, then a single fetch
      F_Req = 1'b1;
      repeat (3) cyc();
      #1;
      chk("rst_f_ready", F_Ready, 0);
      chk("rst_mem_en", Mem_En, 0);
      chk("rst_f_rdata", F_RData, 0);
      chk("rst_d_rdata", D_RData, 0);
      chk("rst_state", dbg_state, 0);
      cyc();
      Reset_n = 1'b1;
      F_Addr  = 16'h0010;
      #1;
      chk("t1_f_ready", F_Ready, 1);
      chk("t1_d_ready", D_Ready, 0);
      chk("t1_mem_en", Mem_En, 1);
      chk("t1_mem_addr", Mem_Addr, 16'h0010);
      chk("t1_mem_we", Mem_We, 0);
      exp_q.push_back(16'hA5B5);
      cyc();
      F_Req = 1'b0;
      #1;
      chk("t1_busy_ready", F_Ready, 0);
      chk("t1_busy_mem_en", Mem_En, 0);
      chk("t1_busy_mem_addr", Mem_Addr, 0);
      chk("t1_busy_state", dbg_state, 1);
      cyc(); #1;
      chk("t1_rvalid_t2", F_RValid, 0);
      cyc(); #1;
      chk("t1_rvalid_t3", F_RValid, 1);
      chk("t1_f_rdata", F_RData, exp_q.pop_front());
      chk("t1_idle_t3", dbg_state, 0);
      cyc(); #1;
      chk("t1_rvalid_t4", F_RValid, 0);
      chk("t1_rdata_hold", F_RData, 16'hA5B5);

      // 2: data write then read-back, read granted in the write's RValid cycle
      cyc();
      D_Req = 1'b1; D_We = 1'b1; D_Addr = 16'h0200; D_WData = 16'hBEEF;
      #1;
      chk("t2_w_ready", D_Ready, 1);
      chk("t2_w_mem_we", Mem_We, 1);
      chk("t2_w_mem_addr", Mem_Addr, 16'h0200);
      chk("t2_w_mem_wdata", Mem_WData, 16'hBEEF);
      cyc();
      D_Req = 1'b0; D_We = 1'b0; D_WData = 16'h0000;
      wait_done(1, n);
      chk("t2_w_latency", n, 2);
      chk("t2_w_rdata_keep", D_RData, 0);
      D_Req = 1'b1;
      #1;
      chk("t2_r_ready", D_Ready, 1);
      chk("t2_r_mem_we", Mem_We, 0);
      exp_q.push_back(16'hBEEF);
      cyc();
      D_Req = 1'b0;
      wait_done(1, n);
      chk("t2_r_latency", n, 2);
      chk("t2_r_rdata", D_RData, exp_q.pop_front());

      // 3: F and D held continuously, last grant was D so F leads
      cyc();
      F_Req = 1'b1; D_Req = 1'b1; F_Addr = 16'h0020; D_Addr = 16'h0200;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) cyc();
         #1;
         if (F_RValid) chk("t3_f_data", F_RData, exp_q.pop_front());
         if (D_RValid) chk("t3_d_data", D_RData, exp_q.pop_front());
         if (F_Ready) begin g_port.push_back(0); g_cyc.push_back(i); exp_q.push_back(16'hA585); end
         if (D_Ready) begin g_port.push_back(1); g_cyc.push_back(i); exp_q.push_back(16'hBEEF); end
      end
      chk("t3_ngrants", g_port.size(), 4);
      if (g_port.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            chk("t3_order", g_port[k], k % 2);
            chk("t3_spacing", g_cyc[k], 3 * k);
         end
      end
      cyc();
      F_Req = 1'b0; D_Req = 1'b0;
      #1;
      chk("t3_last_rvalid", D_RValid, 1);
      chk("t3_last_data", D_RData, exp_q.pop_front());

      // 4: reset asserted in BUSY abandons the access
      cyc();
      D_Req = 1'b1; D_Addr = 16'h0020;
      #1;
      chk("t4_d_ready", D_Ready, 1);
      cyc();
      F_Req = 1'b1;
      Reset_n = 1'b0;
      #1;
      chk("t4_rst_mem_en", Mem_En, 0);
      chk("t4_rst_f_ready", F_Ready, 0);
      chk("t4_rst_d_ready", D_Ready, 0);
      chk("t4_rst_d_rdata", D_RData, 0);
      chk("t4_rst_f_rdata", F_RData, 0);
      chk("t4_rst_state", dbg_state, 0);
      cyc();
      F_Req = 1'b0; D_Req = 1'b0;
      Reset_n = 1'b1;
      rv_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(); #1;
         if (F_RValid || D_RValid) rv_cnt++;
      end
      chk("t4_no_rvalid", rv_cnt, 0);
      cyc();
      F_Req = 1'b1; D_Req = 1'b1; F_Addr = 16'h0010;
      #1;
      chk("t4_f_first", F_Ready, 1);
      chk("t4_d_waits", D_Ready, 0);
      exp_q.push_back(16'hA5B5);

      // 5: D drops its request while F is busy; never granted
      cyc();
      F_Req = 1'b0; D_Req = 1'b0;
      #1;
      chk("t5_d_ready_t1", D_Ready, 0);
      chk("t5_mem_en_t1", Mem_En, 0);
      cyc(); #1;
      chk("t5_mem_en_t2", Mem_En, 0);
      cyc(); #1;
      chk("t5_f_rvalid", F_RValid, 1);
      chk("t5_f_rdata", F_RData, exp_q.pop_front());
      chk("t5_d_ready_t3", D_Ready, 0);
      chk("t5_mem_en_t3", Mem_En, 0);
      cyc();
      F_Req = 1'b1; F_Addr = 16'h0030;
      #1;
      chk("t5_f2_ready", F_Ready, 1);
      chk("t5_f2_addr", Mem_Addr, 16'h0030);
      exp_q.push_back(16'hA595);
      cyc();
      F_Req = 1'b0;
      wait_done(0, n);
      chk("t5_f2_latency", n, 2);
      chk("t5_f2_rdata", F_RData, exp_q.pop_front());

`ifdef MEM_ARB_LOADER_EN
      // 6: three-way rotation; loader write seen by the next fetch
      cyc(); Reset_n = 1'b0;
      cyc(); Reset_n = 1'b1;
      F_Req = 1'b1; F_Addr = 16'h0000;
      D_Req = 1'b1; D_We = 1'b0; D_Addr = 16'h0200;
      L_Req = 1'b1; L_We = 1'b1; L_Addr = 16'h0000; L_WData = 16'h1234;
      g_port.delete();
      f_last = '0;
      for (int i = 0; i < 13; i++) begin
         if (i > 0) cyc();
         #1;
         if (F_RValid) f_last = F_RData;
         if (i < 12) begin
            if (F_Ready) g_port.push_back(0);
            if (D_Ready) g_port.push_back(1);
            if (L_Ready) g_port.push_back(2);
         end
      end
      chk("t6_ngrants", g_port.size(), 4);
      if (g_port.size() == 4) begin
         chk("t6_g0", g_port[0], 0);
         chk("t6_g1", g_port[1], 1);
         chk("t6_g2", g_port[2], 2);
         chk("t6_g3", g_port[3], 0);
      end
      chk("t6_f_sees_l_write", f_last, 16'h1234);
      cyc();
      F_Req = 1'b0; D_Req = 1'b0; L_Req = 1'b0;
`endif

      repeat (4) cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
